// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin memory controller behind the MMU.
//
// Two request ports (0 = IF, 1 = MEM) arrive on flattened buses. Each port
// owns one pending slot; a valid read/write flag on an idle port is latched
// into that slot and the port reports busy until its access completes. A
// two-state FSM (IDLE/ACCESS) grants one pending slot at a time onto a single
// word-wide memory bus with a req/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_rw_flag[3:0]      2 bits per port: 0 idle, 1 read, 2 write, 3 ignored
//   i_addr              per-port word address (AW bits each)
//   i_write_data        per-port write data (DW bits each)
//   i_write_mask        per-port byte enables (DW/8 bits each)
//   o_read_data         per-port read-data slot, held until next read done
//   o_busy[1:0]         request accepted and not yet completed
//   o_done[1:0]         one-cycle completion pulse
//   o_mem_req/we/addr/wdata/wmask   memory request bus
//   i_mem_rdata, i_mem_ready        memory response
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            i_rw_flag,
  input  logic [2*AW-1:0]       i_addr,
  input  logic [2*DW-1:0]       i_write_data,
  input  logic [2*(DW/8)-1:0]   i_write_mask,
  output logic [2*DW-1:0]       o_read_data,
  output logic [1:0]            o_busy,
  output logic [1:0]            o_done,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [AW-1:0]         o_mem_addr,
  output logic [DW-1:0]         o_mem_wdata,
  output logic [DW/8-1:0]       o_mem_wmask,
  input  logic [DW-1:0]         i_mem_rdata,
  input  logic                  i_mem_ready
);

  localparam int MW = DW / 8;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic            last_grant_reg, grant_next;
  logic            grant_en;
  logic            complete;
  logic [1:0]      done_reg;
  logic            mem_we_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [DW-1:0]   mem_wdata_reg;
  logic [MW-1:0]   mem_wmask_reg;

  // Flattened views of the per-port pending slots.
  logic [1:0]      busy_w;
  logic [1:0]      pend_we_w;
  logic [2*AW-1:0] pend_addr_w;
  logic [2*DW-1:0] pend_wdata_w;
  logic [2*MW-1:0] pend_mask_w;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [1:0]    flag;
      logic          capture;
      logic          release_port;
      logic          valid_reg;
      logic          we_reg;
      logic [AW-1:0] addr_reg;
      logic [DW-1:0] wdata_reg;
      logic [MW-1:0] mask_reg;
      logic [DW-1:0] rdata_reg;

      assign flag = i_rw_flag[2*gi +: 2];
      // Only an idle port accepts; the valid bit doubles as o_busy, so a
      // capture and a release can never hit the same slot on one edge.
      assign capture      = !valid_reg && (flag == 2'd1 || flag == 2'd2);
      assign release_port = complete && (last_grant_reg == 1'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          we_reg    <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          mask_reg  <= '0;
          rdata_reg <= '0;
        end else begin
          if (capture) begin
            valid_reg <= 1'b1;
            we_reg    <= (flag == 2'd2);
            addr_reg  <= i_addr[AW*gi +: AW];
            wdata_reg <= i_write_data[DW*gi +: DW];
            mask_reg  <= i_write_mask[MW*gi +: MW];
          end else if (release_port) begin
            valid_reg <= 1'b0;
          end
          if (release_port && !mem_we_reg) begin
            rdata_reg <= i_mem_rdata;
          end
        end
      end

      assign busy_w[gi]                 = valid_reg;
      assign pend_we_w[gi]              = we_reg;
      assign pend_addr_w[AW*gi +: AW]   = addr_reg;
      assign pend_wdata_w[DW*gi +: DW]  = wdata_reg;
      assign pend_mask_w[MW*gi +: MW]   = mask_reg;
      assign o_read_data[DW*gi +: DW]   = rdata_reg;
    end
  endgenerate

  // Next-state / grant decision.
  always_comb begin
    state_next = state_reg;
    grant_next = last_grant_reg;
    grant_en   = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (busy_w != 2'b00) begin
          grant_en   = 1'b1;
          state_next = ACCESS;
          // Tie goes to the port that was not served last; otherwise the
          // single pending port (busy_w[1] names it when only one is set).
          grant_next = (busy_w == 2'b11) ? ~last_grant_reg : busy_w[1];
        end
      end
      ACCESS: begin
        if (i_mem_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_mask;

  assign sel_we    = grant_next ? pend_we_w[1] : pend_we_w[0];
  assign sel_addr  = grant_next ? pend_addr_w[2*AW-1:AW]  : pend_addr_w[AW-1:0];
  assign sel_wdata = grant_next ? pend_wdata_w[2*DW-1:DW] : pend_wdata_w[DW-1:0];
  assign sel_mask  = grant_next ? pend_mask_w[2*MW-1:MW]  : pend_mask_w[MW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;   // IF wins the first tie
      done_reg       <= 2'b00;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wmask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 2'b00;
      if (grant_en) begin
        // Bus fields are frozen here for the whole ACCESS phase.
        last_grant_reg <= grant_next;
        mem_we_reg     <= sel_we;
        mem_addr_reg   <= sel_addr;
        mem_wdata_reg  <= sel_we ? sel_wdata : '0;
        mem_wmask_reg  <= sel_we ? sel_mask  : '0;
      end
      if (complete) begin
        done_reg <= last_grant_reg ? 2'b10 : 2'b01;
      end
    end
  end

  assign o_busy      = busy_w;
  assign o_done      = done_reg;
  assign o_mem_req   = (state_reg == ACCESS);
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_wmask = mem_wmask_reg;

endmodule
